// File: rtl/life_grid_engine_if.sv
// rtl/life_grid_engine_if.sv - command, pixel-stream and status bundle for the life grid engine
interface life_grid_engine_if #(
    parameter int COORD_W = 8
);
    logic               load;
    logic [COORD_W-1:0] x_in;
    logic [COORD_W-1:0] y_in;
    logic [2:0]         in_colour;
    logic               step;
    logic               clear;
    logic               plot;
    logic               plot_ready;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic [2:0]         out_colour;
    logic               busy;
    logic [15:0]        gen_count;
    logic [14:0]        alive_count;

    modport master (
        output load, x_in, y_in, in_colour, step, clear, plot_ready,
        input  plot, out_x, out_y, out_colour, busy, gen_count, alive_count
    );

    modport slave (
        input  load, x_in, y_in, in_colour, step, clear, plot_ready,
        output plot, out_x, out_y, out_colour, busy, gen_count, alive_count
    );
endinterface

// File: rtl/life_grid_engine.sv
// rtl/life_grid_engine.sv - B3/S23 cellular automaton with double-buffered grid and pixel plot stream
module life_grid_engine #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int COORD_W = 8,
    parameter int WRAP    = 0
) (
    input  logic              clock,
    input  logic              reset,
    life_grid_engine_if.slave bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    typedef enum logic [2:0] {IDLE, LOAD_PLOT, COMPUTE, DRAW, CLEAR} state_t;

    state_t             state, state_d;
    logic [GRID_W-1:0]  cur [GRID_H];
    logic [GRID_W-1:0]  nxt [GRID_H];
    logic [XW-1:0]      sx, xm, xp, lx;
    logic [YW-1:0]      sy, ym, yp, ly;
    logic               x_lo_ok, x_hi_ok, y_lo_ok, y_hi_ok;
    logic [7:0]         nb;
    logic [3:0]         nbr;
    logic               cell_now, cell_next, last_cell, changed, xfer, load_ok;
    logic               scan_adv, plot_start;
    logic               plot_r;
    logic [COORD_W-1:0] ox, oy;
    logic [2:0]         oc, colour_r;
    logic [15:0]        gen_r;
    logic [14:0]        alive_r;

    // Neighbourhood of the scan cell; edge flags mask off-grid cells unless wrapping.
    always_comb begin
        xm = (sx == '0) ? XW'(GRID_W - 1) : sx - XW'(1);
        xp = (sx == XW'(GRID_W - 1)) ? '0 : sx + XW'(1);
        ym = (sy == '0) ? YW'(GRID_H - 1) : sy - YW'(1);
        yp = (sy == YW'(GRID_H - 1)) ? '0 : sy + YW'(1);
        x_lo_ok = (WRAP != 0) || (sx != '0);
        x_hi_ok = (WRAP != 0) || (sx != XW'(GRID_W - 1));
        y_lo_ok = (WRAP != 0) || (sy != '0);
        y_hi_ok = (WRAP != 0) || (sy != YW'(GRID_H - 1));
        nb = {cur[ym][xm] & y_lo_ok & x_lo_ok, cur[ym][sx] & y_lo_ok,
              cur[ym][xp] & y_lo_ok & x_hi_ok, cur[sy][xm] & x_lo_ok,
              cur[sy][xp] & x_hi_ok,           cur[yp][xm] & y_hi_ok & x_lo_ok,
              cur[yp][sx] & y_hi_ok,           cur[yp][xp] & y_hi_ok & x_hi_ok};
        nbr = '0;
        for (int i = 0; i < 8; i++) begin
            nbr = nbr + 4'(nb[i]);
        end
        cell_now  = cur[sy][sx];
        cell_next = (nbr == 4'd3) || (cell_now && nbr == 4'd2);
        changed   = nxt[sy][sx] != cur[sy][sx];
        last_cell = (sx == XW'(GRID_W - 1)) && (sy == YW'(GRID_H - 1));
        xfer      = plot_r && bus.plot_ready;
        lx        = XW'(bus.x_in);
        ly        = YW'(bus.y_in);
        load_ok   = bus.load && (int'(bus.x_in) < GRID_W) && (int'(bus.y_in) < GRID_H);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        scan_adv   = 1'b0;
        plot_start = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear)     state_d = CLEAR;
                else if (bus.step) state_d = COMPUTE;
                else if (load_ok)  state_d = LOAD_PLOT;
            end
            LOAD_PLOT: if (xfer) state_d = IDLE;
            COMPUTE: begin
                scan_adv = 1'b1;
                if (last_cell) state_d = DRAW;
            end
            DRAW, CLEAR: begin
                // A cell needing a pixel holds the scan until its transfer completes.
                if (plot_r)                                        scan_adv = bus.plot_ready;
                else if ((state == DRAW) ? changed : cell_now)     plot_start = 1'b1;
                else                                               scan_adv = 1'b1;
                if (scan_adv && last_cell) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sx       <= '0;
            sy       <= '0;
            plot_r   <= 1'b0;
            ox       <= '0;
            oy       <= '0;
            oc       <= '0;
            colour_r <= '0;
            gen_r    <= '0;
            alive_r  <= '0;
            for (int r = 0; r < GRID_H; r++) begin
                cur[r] <= '0;
                nxt[r] <= '0;
            end
        end else begin
            if (scan_adv) begin
                if (sx == XW'(GRID_W - 1)) begin
                    sx <= '0;
                    sy <= (sy == YW'(GRID_H - 1)) ? '0 : sy + YW'(1);
                end else begin
                    sx <= sx + XW'(1);
                end
            end
            if (xfer) plot_r <= 1'b0;
            if (plot_start) begin
                plot_r <= 1'b1;
                ox     <= COORD_W'(sx);
                oy     <= COORD_W'(sy);
            end
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        sx <= '0;
                        sy <= '0;
                    end else if (bus.step) begin
                        sx       <= '0;
                        sy       <= '0;
                        colour_r <= bus.in_colour;
                    end else if (load_ok) begin
                        cur[ly][lx] <= 1'b1;
                        if (!cur[ly][lx]) alive_r <= alive_r + 15'd1;
                        plot_r <= 1'b1;
                        ox     <= bus.x_in;
                        oy     <= bus.y_in;
                        oc     <= bus.in_colour;
                    end
                end
                COMPUTE: nxt[sy][sx] <= cell_next;
                DRAW: begin
                    if (plot_start) begin
                        oc          <= nxt[sy][sx] ? colour_r : 3'b000;
                        cur[sy][sx] <= nxt[sy][sx];
                        alive_r     <= nxt[sy][sx] ? alive_r + 15'd1 : alive_r - 15'd1;
                    end
                    if (scan_adv && last_cell) gen_r <= gen_r + 16'd1;
                end
                CLEAR: begin
                    if (plot_start) begin
                        oc          <= 3'b000;
                        cur[sy][sx] <= 1'b0;
                    end
                    if (scan_adv && last_cell) begin
                        alive_r <= '0;
                        gen_r   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.plot        = plot_r;
    assign bus.out_x       = ox;
    assign bus.out_y       = oy;
    assign bus.out_colour  = oc;
    assign bus.busy        = (state != IDLE);
    assign bus.gen_count   = gen_r;
    assign bus.alive_count = alive_r;
endmodule

// File: tb/tb_life_grid_engine.sv
// tb/tb_life_grid_engine.sv - self-checking bench: bounded and toroidal engines against a grid model
module tb_life_grid_engine;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0, step = 1'b0, clear = 1'b0, plot_ready = 1'b0;
    logic [7:0] x_in = '0, y_in = '0;
    logic [2:0] in_colour = '0;

    always #5 clock = ~clock;

    life_grid_engine_if #(.COORD_W(8)) bus0 ();
    life_grid_engine_if #(.COORD_W(8)) bus1 ();

    assign bus0.load = load;           assign bus1.load = load;
    assign bus0.step = step;           assign bus1.step = step;
    assign bus0.clear = clear;         assign bus1.clear = clear;
    assign bus0.x_in = x_in;           assign bus1.x_in = x_in;
    assign bus0.y_in = y_in;           assign bus1.y_in = y_in;
    assign bus0.in_colour = in_colour; assign bus1.in_colour = in_colour;
    assign bus0.plot_ready = plot_ready;
    assign bus1.plot_ready = plot_ready;

    life_grid_engine #(.GRID_W(16), .GRID_H(16), .COORD_W(8), .WRAP(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0));
    life_grid_engine #(.GRID_W(16), .GRID_H(16), .COORD_W(8), .WRAP(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1));

    int  checks = 0;
    int  errors = 0;
    bit  rand_mode = 1'b0;
    bit  ready_val = 1'b1;

    logic [18:0] q0[$], q1[$], e0[$], e1[$];
    int          mg [2][16][16];
    int          m_alive [2];
    int          m_gen [2];

    typedef struct {
        int x;
        int y;
        int col;
        int exp_plots;
    } load_vec_t;
    load_vec_t lv [6];

    always @(posedge clock) begin
        #1;
        plot_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (bus0.plot && plot_ready) q0.push_back({bus0.out_x, bus0.out_y, bus0.out_colour});
            if (bus1.plot && plot_ready) q1.push_back({bus1.out_x, bus1.out_y, bus1.out_colour});
        end
    end

    function automatic int pk(input int x, input int y, input int c);
        return (x << 11) | (y << 3) | c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int d, input int x, input int y, input int c);
        logic [18:0] v;
        v = {8'(x), 8'(y), 3'(c)};
        if (d == 0) e0.push_back(v);
        else        e1.push_back(v);
    endfunction

    function automatic void model_load(input int x, input int y, input int c);
        if (x < 16 && y < 16) begin
            for (int d = 0; d < 2; d++) begin
                if (mg[d][y][x] == 0) m_alive[d]++;
                mg[d][y][x] = 1;
                push_exp(d, x, y, c);
            end
        end
    endfunction

    function automatic void model_step(input int c);
        for (int d = 0; d < 2; d++) begin
            int nx [16][16];
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 16; x++) begin
                    int n;
                    n = 0;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            int xx, yy;
                            xx = x + dx;
                            yy = y + dy;
                            if (d == 1) begin
                                xx = (xx + 16) % 16;
                                yy = (yy + 16) % 16;
                            end
                            if ((dx != 0 || dy != 0) && xx >= 0 && xx < 16 && yy >= 0 && yy < 16)
                                n += mg[d][yy][xx];
                        end
                    end
                    nx[y][x] = (n == 3 || (mg[d][y][x] == 1 && n == 2)) ? 1 : 0;
                end
            end
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 16; x++) begin
                    if (nx[y][x] != mg[d][y][x]) begin
                        push_exp(d, x, y, nx[y][x] == 1 ? c : 0);
                        m_alive[d] += (nx[y][x] == 1) ? 1 : -1;
                        mg[d][y][x] = nx[y][x];
                    end
                end
            end
            m_gen[d] = (m_gen[d] + 1) % 65536;
        end
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    if (mg[d][y][x] == 1) begin
                        push_exp(d, x, y, 0);
                        mg[d][y][x] = 0;
                    end
            m_alive[d] = 0;
            m_gen[d]   = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    mg[d][y][x] = 0;
            m_alive[d] = 0;
            m_gen[d]   = 0;
        end
    endfunction

    task automatic do_cmd(input bit l, input bit s, input bit c, input int x, input int y, input int col);
        @(posedge clock); #1;
        load = l; step = s; clear = c;
        x_in = 8'(x); y_in = 8'(y); in_colour = 3'(col);
        @(posedge clock); #1;
        load = 1'b0; step = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((bus0.busy || bus1.busy) && n < 5000);
        if (n >= 5000) chk("idle_timeout", 1, 0);
    endtask

    task automatic compare_all(input string name);
        chk({name, "_nplots0"}, q0.size(), e0.size());
        for (int i = 0; i < q0.size() && i < e0.size(); i++) chk({name, "_plot0"}, int'(q0[i]), int'(e0[i]));
        chk({name, "_nplots1"}, q1.size(), e1.size());
        for (int i = 0; i < q1.size() && i < e1.size(); i++) chk({name, "_plot1"}, int'(q1[i]), int'(e1[i]));
        chk({name, "_alive0"}, int'(bus0.alive_count), m_alive[0]);
        chk({name, "_alive1"}, int'(bus1.alive_count), m_alive[1]);
        chk({name, "_gen0"}, int'(bus0.gen_count), m_gen[0]);
        chk({name, "_gen1"}, int'(bus1.gen_count), m_gen[1]);
        chk({name, "_plot_idle"}, int'(bus0.plot), 0);
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
    endtask

    initial begin
        logic [19:0] held;
        int          n;
        lv[0] = '{x: 5,  y: 4,  col: 3, exp_plots: 1};
        lv[1] = '{x: 5,  y: 5,  col: 3, exp_plots: 1};
        lv[2] = '{x: 5,  y: 6,  col: 3, exp_plots: 1};
        lv[3] = '{x: 16, y: 3,  col: 2, exp_plots: 0};
        lv[4] = '{x: 3,  y: 16, col: 2, exp_plots: 0};
        lv[5] = '{x: 5,  y: 5,  col: 6, exp_plots: 1};
        model_reset();

        repeat (2) @(negedge clock);
        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_plot", int'(bus0.plot), 0);
        chk("rst_out", pk(int'(bus0.out_x), int'(bus0.out_y), int'(bus0.out_colour)), 0);
        chk("rst_gen", int'(bus0.gen_count), 0);
        chk("rst_alive", int'(bus1.alive_count), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_cmd(1, 0, 0, lv[i].x, lv[i].y, lv[i].col);
            wait_idle();
            chk("load_plot_count", q0.size(), lv[i].exp_plots);
            model_load(lv[i].x, lv[i].y, lv[i].col);
            compare_all("load_tbl");
        end

        do_cmd(0, 1, 0, 0, 0, 5);
        wait_idle();
        chk("blinker_nplots", q0.size(), 4);
        if (q0.size() == 4) begin
            chk("blinker_p0", int'(q0[0]), pk(5, 4, 0));
            chk("blinker_p1", int'(q0[1]), pk(4, 5, 5));
            chk("blinker_p2", int'(q0[2]), pk(6, 5, 5));
            chk("blinker_p3", int'(q0[3]), pk(5, 6, 0));
        end
        chk("blinker_alive", int'(bus0.alive_count), 3);
        chk("blinker_gen", int'(bus0.gen_count), 1);
        model_step(5);
        compare_all("blinker");

        do_cmd(1, 0, 0, 1, 1, 7); wait_idle(); model_load(1, 1, 7);
        do_cmd(1, 0, 0, 9, 9, 7); wait_idle(); model_load(9, 9, 7);
        compare_all("pre_clear");
        do_cmd(0, 0, 1, 0, 0, 0);
        wait_idle();
        chk("clear_nplots", q0.size(), 5);
        chk("clear_busy", int'(bus0.busy), 0);
        chk("clear_alive", int'(bus0.alive_count), 0);
        model_clear();
        compare_all("clear");

        for (int r = 4; r <= 6; r++) begin
            do_cmd(1, 0, 0, 0, r, 1);
            wait_idle();
            model_load(0, r, 1);
        end
        compare_all("edge_load");
        do_cmd(0, 1, 0, 0, 0, 2);
        wait_idle();
        chk("wrap_nplots", q1.size(), 4);
        chk("nowrap_nplots", q0.size(), 3);
        if (q1.size() == 4) begin
            chk("wrap_birth_a", int'(q1[1]), pk(1, 5, 2));
            chk("wrap_birth_b", int'(q1[2]), pk(15, 5, 2));
        end
        if (q0.size() == 3) begin
            chk("nowrap_death_a", int'(q0[0]), pk(0, 4, 0));
            chk("nowrap_birth", int'(q0[1]), pk(1, 5, 2));
            chk("nowrap_death_b", int'(q0[2]), pk(0, 6, 0));
        end
        model_step(2);
        compare_all("edge_step");
        do_cmd(0, 0, 1, 0, 0, 0); wait_idle(); model_clear(); compare_all("edge_clear");

        do_cmd(1, 1, 0, 3, 3, 4);
        wait_idle();
        chk("step_load_alive", int'(bus0.alive_count), 0);
        model_step(4);
        compare_all("step_load");
        do_cmd(0, 1, 0, 0, 0, 4);
        do_cmd(1, 0, 0, 7, 7, 4);
        wait_idle();
        model_step(4);
        compare_all("busy_load");

        for (int r = 4; r <= 6; r++) begin
            do_cmd(1, 0, 0, 5, r, 6);
            wait_idle();
            model_load(5, r, 6);
        end
        compare_all("stall_setup");
        ready_val = 1'b0;
        do_cmd(0, 1, 0, 0, 0, 6);
        n = 0;
        while (!bus0.plot && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("stall_plot_seen", int'(bus0.plot), 1);
        held = {bus0.plot, bus0.out_x, bus0.out_y, bus0.out_colour};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall_hold", int'({bus0.plot, bus0.out_x, bus0.out_y, bus0.out_colour}), int'(held));
        end
        ready_val = 1'b1;
        wait_idle();
        model_step(6);
        compare_all("stall");

        do_cmd(0, 0, 1, 0, 0, 0); wait_idle(); model_clear(); compare_all("rand_clear");
        rand_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 14; k++) begin
                int x, y, c;
                x = $urandom_range(0, 17);
                y = $urandom_range(0, 17);
                c = $urandom_range(0, 7);
                do_cmd(1, 0, 0, x, y, c);
                wait_idle();
                model_load(x, y, c);
            end
            compare_all("rand_load");
            for (int s = 0; s < 2; s++) begin
                int c;
                c = $urandom_range(1, 7);
                do_cmd(0, 1, 0, 0, 0, c);
                wait_idle();
                model_step(c);
                compare_all("rand_step");
            end
        end
        rand_mode = 1'b0;
        ready_val = 1'b1;

        do_cmd(1, 0, 0, 2, 2, 3); wait_idle(); model_load(2, 2, 3);
        do_cmd(1, 0, 0, 3, 2, 3); wait_idle(); model_load(3, 2, 3);
        do_cmd(1, 0, 0, 4, 2, 3); wait_idle(); model_load(4, 2, 3);
        compare_all("pre_reset");
        do_cmd(0, 1, 0, 0, 0, 3);
        repeat (39) @(posedge clock);
        #1;
        chk("compute_busy", int'(bus0.busy), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", int'(bus0.busy), 0);
        chk("midrst_plot", int'(bus0.plot), 0);
        chk("midrst_alive", int'(bus0.alive_count), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
        do_cmd(0, 1, 0, 0, 0, 3);
        wait_idle();
        chk("post_rst_nplots", q0.size(), 0);
        model_step(3);
        compare_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/life_grid_engine.md
LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 16: grid columns, 2..128.
REQ-002 SHALL have parameter GRID_H, default 16: grid rows, 2..120.
REQ-003 SHALL have parameter COORD_W, default 8: width of x/y coordinate ports.
REQ-004 SHALL have parameter WRAP, default 0: 0 = cells beyond the edge are dead; 1 = toroidal neighbourhood.
REQ-005 SHALL have port clock  in  1  single clock, all state on the rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port load  in  1  pulse: set cell (x_in,y_in) alive.
REQ-008 SHALL have ports x_in, y_in  in  COORD_W each  load coordinates.
REQ-009 SHALL have port in_colour  in  3  colour for newly born cells.
REQ-010 SHALL have port step  in  1  pulse: compute and draw one generation.
REQ-011 SHALL have port clear  in  1  pulse: kill all cells and erase them on screen.
REQ-012 SHALL have port plot  out  1  out_x/out_y/out_colour valid.
REQ-013 SHALL have port plot_ready  in  1  pixel sink accepts this cycle.
REQ-014 SHALL have ports out_x, out_y  out  COORD_W each  pixel coordinates.
REQ-015 SHALL have port out_colour  out  3  pixel colour.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-017 SHALL have port gen_count  out  16  generations completed.
REQ-018 SHALL have port alive_count  out  15  live cells in the current grid.

Function
REQ-019 SHALL hold a current grid cur[GRID_H][GRID_W] and a shadow grid nxt of the same size.
REQ-020 SHALL implement states IDLE, LOAD_PLOT, COMPUTE, DRAW, CLEAR.
REQ-021 SHALL, in IDLE, accept commands with priority clear > step > load; lower-priority pulses in the same cycle are dropped.
REQ-022 SHALL ignore load, step and clear while busy; they are not queued.
REQ-023 SHALL, on load in IDLE with x_in<GRID_W and y_in<GRID_H, set cur[y][x]=1, increment alive_count if the cell was dead, and enter LOAD_PLOT with plot=1, out=(x_in,y_in,in_colour).
REQ-024 SHALL ignore load with an out-of-range coordinate: no state change, no plot.
REQ-025 SHALL, in every plotting state, hold plot and the out_* values stable until a cycle with plot&&plot_ready, which completes the transfer.
REQ-026 SHALL exit LOAD_PLOT to IDLE in the cycle after the transfer completes.
REQ-027 SHALL, on step, enter COMPUTE and scan cells row-major from (0,0), one cell per cycle, writing nxt by standard B3/S23 rules; COMPUTE lasts exactly GRID_W*GRID_H cycles, and plot=0 throughout.
REQ-028 SHALL count neighbours from cur only; nxt SHALL NOT affect any neighbour count in the same generation.
REQ-029 SHALL, with WRAP=0, treat out-of-grid neighbours as dead; with WRAP=1, index neighbours modulo GRID_W/GRID_H, so column -1 maps to GRID_W-1.
REQ-030 SHALL, in DRAW, scan row-major: an unchanged cell costs 1 cycle; a changed cell asserts plot with colour in_colour (birth) or 3'b000 (death), copies nxt into cur, and waits for the transfer.
REQ-031 SHALL update alive_count by +1 per birth and -1 per death as each cell is committed.
REQ-032 SHALL, after the last cell of DRAW, increment gen_count (wrapping 0xFFFF->0) and return to IDLE.
REQ-033 SHALL treat a generation with no changes as taking GRID_W*GRID_H cycles in DRAW with no plots, and SHALL still increment gen_count.
REQ-034 SHALL, in CLEAR, scan row-major: each live cell plots colour 3'b000 and is cleared; at the end, alive_count=0, gen_count=0, and the block returns to IDLE.
REQ-035 SHALL sample in_colour at the step command and use that value for the whole generation.

Reset
REQ-036 SHALL, on reset, immediately set state=IDLE, plot=0, busy=0, out_x=out_y=0, out_colour=0, gen_count=0, alive_count=0, and all cells of cur and nxt to 0.
REQ-037 SHALL, on reset asserted mid-COMPUTE, DRAW or a pending transfer, abandon the operation with no further plot; the on-screen image is not erased.

Verification
REQ-038 Bench SHALL cover: 16x16, WRAP=0, load (5,4),(5,5),(5,6), step, plot_ready=1 -> exactly 4 plots: (4,5) and (6,5) with in_colour, (5,4) and (5,6) with 000; alive_count=3; gen_count=1.
REQ-039 Bench SHALL cover: WRAP=1, vertical blinker at column 0, rows 4..6, step -> births at (15,5) and (1,5); with WRAP=0 there is one birth, at (1,5), plus deaths at (0,4) and (0,6).
REQ-040 Bench SHALL cover: plot_ready held low for 10 cycles during the first DRAW plot -> plot and out_* stay constant for those 10 cycles, then the scan resumes, with the same final grid as with no stall.
REQ-041 Bench SHALL cover: load (16,3) on a 16x16 grid -> no plot, alive_count unchanged; step+load in the same IDLE cycle -> the load is dropped.
REQ-042 Bench SHALL cover: reset asserted in the 40th cycle of COMPUTE -> next cycle busy=0, plot=0, alive_count=0, and a following step produces zero plots.
REQ-043 Bench SHALL cover: 5 live cells, clear -> exactly 5 plots of colour 000 in row-major order, then alive_count=0, gen_count=0, busy=0.
